// File: rtl/filter_mem_arbiter.sv
// filter_mem_arbiter: two-port arbiter in front of a byte-wide memory that
// holds a sample region (below FILTER_ADDR) and a coefficient region.
// Port A has priority. A saturating starve counter guarantees port B a turn
// after STARVE_LIMIT consecutive port-A beats.
// Optional feature: define FILTER_ARB_WRITE_PROTECT_EN to block port-B writes
// into the sample region. A blocked write still counts as an issued beat and
// is reported on ErrB.
//
// Handshake: a beat issues at an edge where the owner's Req and Grant are both
// 1. Grant is the "ready" side and Req is the "valid" side. A read issued at
// edge k returns RData with a one-cycle RValid for the issuing port after edge
// k+1.
module filter_mem_arbiter #(
  parameter logic [15:0] FILTER_ADDR  = 16'h8000,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic        LockA,
  input  logic        LockB,
  input  logic        WriteA,
  input  logic        WriteB,
  input  logic [15:0] AddrA,
  input  logic [15:0] AddrB,
  input  logic [7:0]  WDataA,
  input  logic [7:0]  WDataB,
  output logic        GrantA,
  output logic        GrantB,
  output logic [7:0]  RData,
  output logic        RValidA,
  output logic        RValidB,
  output logic        ErrB,
  output logic [15:0] MemAddr,
  inout  wire  [7:0]  MemData,
  output logic        MemWrite,
  output logic        MemClk,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_starve_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

`ifdef FILTER_ARB_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d, starve_inc;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_write_q, mem_write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_pend_a_q, rd_pend_a_d;
  logic        rd_pend_b_q, rd_pend_b_d;
  logic        rvalid_a_q, rvalid_a_d;
  logic        rvalid_b_q, rvalid_b_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        issue_a, issue_b, wp_block;

  // Beat issue detection and write-protect decision for port B.
  always_comb begin
    issue_a  = (state_q == S_OWN_A) && ReqA;
    issue_b  = (state_q == S_OWN_B) && ReqB;
    wp_block = WP_EN && issue_b && WriteB && (AddrB < FILTER_ADDR);
  end

  // Starve counter: count A beats while B waits, saturate, clear on B entry.
  always_comb begin
    starve_inc = starve_q;
    if (issue_a && ReqB && (starve_q != LIMIT)) starve_inc = starve_q + 8'd1;
    starve_d = starve_inc;
    if ((state_d == S_OWN_B) && (state_q != S_OWN_B)) starve_d = 8'd0;
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: A wins ties unless B has starved; locks hold ownership.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ReqA && ReqB) state_d = (starve_q == LIMIT) ? S_OWN_B : S_OWN_A;
        else if (ReqA)    state_d = S_OWN_A;
        else if (ReqB)    state_d = S_OWN_B;
      end
      S_OWN_A: begin
        if (!LockA) begin
          if (ReqB && (!ReqA || (starve_inc == LIMIT))) state_d = S_OWN_B;
          else if (ReqA)                                 state_d = S_OWN_A;
          else                                           state_d = S_IDLE;
        end
      end
      S_OWN_B: begin
        if (!LockB) begin
          if (ReqA)      state_d = S_OWN_A;
          else if (ReqB) state_d = S_OWN_B;
          else           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    GrantA         = (state_q == S_OWN_A);
    GrantB         = (state_q == S_OWN_B);
    dbg_state      = state_q;
    dbg_starve_cnt = starve_q;
  end

  // Memory request path and read-return pipeline.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_write_d = 1'b0;
    wdata_d     = wdata_q;
    rd_pend_a_d = issue_a && !WriteA;
    rd_pend_b_d = issue_b && !WriteB;
    rvalid_a_d  = rd_pend_a_q;
    rvalid_b_d  = rd_pend_b_q;
    rdata_d     = (rd_pend_a_q || rd_pend_b_q) ? MemData : rdata_q;
    err_d       = wp_block;
    if (issue_a) begin
      mem_addr_d  = AddrA;
      mem_write_d = WriteA;
      wdata_d     = WDataA;
    end else if (issue_b && !wp_block) begin
      mem_addr_d  = AddrB;
      mem_write_d = WriteB;
      wdata_d     = WDataB;
    end
  end

  // Datapath registers; reset also discards any read still in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      starve_q    <= 8'd0;
      mem_addr_q  <= 16'd0;
      mem_write_q <= 1'b0;
      wdata_q     <= 8'd0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_q     <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Registered outputs and the memory-side pins.
  assign MemAddr  = mem_addr_q;
  assign MemWrite = mem_write_q;
  assign MemData  = mem_write_q ? wdata_q : 8'bz;
  assign MemClk   = ~Clock;
  assign RData    = rdata_q;
  assign RValidA  = rvalid_a_q;
  assign RValidB  = rvalid_b_q;
  assign ErrB     = err_q;

endmodule
